imem_dmem_arbiter: RTL and testbench



---
 rtl/imem_dmem_arbiter_pkg.sv | 20 ++
 rtl/imem_dmem_arbiter_starve_ctr.sv | 38 +++
 rtl/imem_dmem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// requester IDs, the default address width and the data-lane byte reversal.
package imem_dmem_arb_pkg;

    localparam int REQ_IF = 0;
    localparam int REQ_D  = 1;

    localparam int DEFAULT_ADDR_W = 12;

    // Reverse the four byte lanes of a 32-bit word.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Reverse the four byte-enable bits so they follow bswap32 lane moves.
    function automatic logic [3:0] bswap4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// Saturating counter of consecutive data grants made while fetch waits.
// at_limit tells the arbiter to hand the next slot to fetch.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    assign at_limit = (cnt_reg == MAX_C);

    // Clear wins over increment; hold once the limit is reached.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = 4'd0;
        end else if (inc && !at_limit) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    // Counter state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous word memory between the fetch port and
// the data load/store port. Data has priority; a starvation counter forces a
// fetch grant after MAX_DATA_BURST consecutive data grants. One access per
// cycle, responses one cycle later, routed back by per-port tag registers.
module imem_dmem_arbiter
    import imem_dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int MAX_DATA_BURST = 4,
    parameter int BSWAP_DATA     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [31:0]       d_req_addr,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    logic [1:0]  grant;
    logic        at_limit;
    logic        rsp_if_reg;
    logic        rsp_d_reg;
    logic        rsp_d_we_reg;
    logic [31:0] d_wdata_lane;
    logic [3:0]  d_wstrb_lane;
    logic [31:0] d_rdata_lane;

    // Byte-offset bits and bits above the word address are deliberately
    // dropped so addresses wrap around the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                                d_req_addr[31:ADDR_W+2], d_req_addr[1:0]};

    // Lane reversal applies to the data port only; fetch is never swapped.
    assign d_wdata_lane = (BSWAP_DATA != 0) ? bswap32(d_req_wdata) : d_req_wdata;
    assign d_wstrb_lane = (BSWAP_DATA != 0) ? bswap4(d_req_wstrb)  : d_req_wstrb;
    assign d_rdata_lane = (BSWAP_DATA != 0) ? bswap32(mem_rdata)   : mem_rdata;

    // Grant: data first unless fetch has waited MAX_DATA_BURST data grants.
    // Nothing is granted while reset is asserted.
    always_comb begin
        grant         = 2'b00;
        grant[REQ_D]  = rst_n & d_req_valid & (~if_req_valid | ~at_limit);
        grant[REQ_IF] = rst_n & if_req_valid & ~grant[REQ_D];
    end

    assign if_req_ready = grant[REQ_IF];
    assign d_req_ready  = grant[REQ_D];

    arb_starve_ctr #(
        .MAX (MAX_DATA_BURST)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (grant[REQ_IF] | ~if_req_valid),
        .inc      (grant[REQ_D] & if_req_valid),
        .at_limit (at_limit)
    );

    // Drive the memory directly in the cycle a request is accepted.
    always_comb begin
        mem_en    = grant[REQ_IF] | grant[REQ_D];
        mem_we    = 4'b0000;
        mem_addr  = if_req_addr[ADDR_W+1:2];
        mem_wdata = d_wdata_lane;
        if (grant[REQ_D]) begin
            mem_addr = d_req_addr[ADDR_W+1:2];
            if (d_req_we) begin
                mem_we = d_wstrb_lane;
            end
        end
    end

    // Response tags remember who owns next cycle's read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_if_reg   <= 1'b0;
            rsp_d_reg    <= 1'b0;
            rsp_d_we_reg <= 1'b0;
        end else begin
            rsp_if_reg   <= grant[REQ_IF];
            rsp_d_reg    <= grant[REQ_D];
            rsp_d_we_reg <= grant[REQ_D] & d_req_we;
        end
    end

    // Responses are combinational off mem_rdata; a flush in the response
    // cycle kills the pending fetch, and reset drops anything in flight.
    always_comb begin
        if_rsp_valid = rst_n & rsp_if_reg & ~if_flush;
        d_rsp_valid  = rst_n & rsp_d_reg;
        if_rsp_data  = if_rsp_valid ? mem_rdata : 32'd0;
        d_rsp_data   = (d_rsp_valid && !rsp_d_we_reg) ? d_rdata_lane : 32'd0;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural synchronous memory
// and a scoreboard of expected responses keyed by the cycle they are due.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] last_gnt;

    typedef struct {
        int          due;
        bit          is_if;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W         (12),
        .MAX_DATA_BURST (4),
        .BSWAP_DATA     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_flush     (if_flush),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_wstrb  (d_req_wstrb),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Behavioural single-port memory: read-before-write, one-cycle latency.
    logic [31:0] mem [0:4095];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hA5000000 ^ (i * 32'h00010003);
            mem_init_done <= 1'b1;
            mem_rdata     <= 32'd0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already set after a negedge. Check responses
    // due now, check and record any issue, then advance to the next negedge.
    task automatic tick();
        rsp_t        e;
        logic        exp_if;
        logic        exp_d;
        logic [31:0] exp_data;
        logic [11:0] aidx;
        #1;
        exp_if = 1'b0; exp_d = 1'b0; exp_data = 32'd0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (rst_n) begin
                if (e.is_if) exp_if = !if_flush;
                else         exp_d  = 1'b1;
                exp_data = e.data;
            end
        end
        chk("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, exp_if});
        chk("d_rsp_valid",  {31'd0, d_rsp_valid},  {31'd0, exp_d});
        if (exp_if) chk("if_rsp_data", if_rsp_data, exp_data);
        if (exp_d)  chk("d_rsp_data",  d_rsp_data,  exp_data);

        last_gnt = "N";
        if (!rst_n) begin
            chk("if_ready_rst", {31'd0, if_req_ready}, 32'd0);
            chk("d_ready_rst",  {31'd0, d_req_ready},  32'd0);
            chk("mem_en_rst",   {31'd0, mem_en},       32'd0);
        end else if (if_req_ready && d_req_ready) begin
            chk("double_grant", 32'd1, 32'd0);
        end else if (if_req_valid && if_req_ready) begin
            aidx = if_req_addr[13:2];
            sb.push_back('{cyc + 1, 1'b1, mem[aidx]});
            chk("mem_en_if",   {31'd0, mem_en}, 32'd1);
            chk("mem_addr_if", {20'd0, mem_addr}, {20'd0, aidx});
            chk("mem_we_if",   {28'd0, mem_we}, 32'd0);
            last_gnt = "I";
        end else if (d_req_valid && d_req_ready) begin
            aidx = d_req_addr[13:2];
            sb.push_back('{cyc + 1, 1'b0, d_req_we ? 32'd0 : rev32(mem[aidx])});
            chk("mem_en_d",   {31'd0, mem_en}, 32'd1);
            chk("mem_addr_d", {20'd0, mem_addr}, {20'd0, aidx});
            chk("mem_we_d",   {28'd0, mem_we}, {28'd0, d_req_we ? rev4(d_req_wstrb) : 4'd0});
            if (d_req_we) chk("mem_wdata_d", mem_wdata, rev32(d_req_wdata));
            last_gnt = "D";
        end else begin
            chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    string exp_pat;

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_flush = 1'b0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0;
        d_req_wdata = 32'd0; d_req_wstrb = 4'd0;
        @(negedge clk);

        // Reset state, with requests pending to show ready stays low.
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        tick();
        tick();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        rst_n = 1'b1;
        chk("starve_cnt_reset", {28'd0, dut.u_starve.cnt_reg}, 32'd0);

        // Back-to-back fetches at 0x0, 0x4, 0x8.
        if_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_addr = 32'(4 * i);
            #1;
            chk("fetch_seq_addr", {20'd0, mem_addr}, 32'(i));
            tick();
        end
        if_req_valid = 1'b0;
        tick();

        // Concurrent streams: four data grants, then a forced fetch.
        exp_pat = "DDDDIDDDDIDD";
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if_req_addr = 32'h20 + 32'(4 * i);
            d_req_addr  = 32'h200 + 32'(4 * i);
            tick();
            chk("grant_pattern", {24'd0, last_gnt}, {24'd0, exp_pat[i]});
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Full-word store with lane swap, then load it back.
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h100;
        d_req_wdata = 32'h11223344; d_req_wstrb = 4'hF;
        #1;
        chk("store_wdata_swap", mem_wdata, 32'h44332211);
        chk("store_we_full", {28'd0, mem_we}, 32'hF);
        tick();
        d_req_we = 1'b0;
        tick();
        d_req_valid = 1'b0;
        #1;
        chk("load_back_data", d_rsp_data, 32'h11223344);
        tick();
        chk("mem_word_0x100", mem[64], 32'h44332211);

        // Single-byte store: strobe lane 0 lands on memory lane 3.
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h104;
        d_req_wdata = 32'hAABBCCDD; d_req_wstrb = 4'b0001;
        tick();
        d_req_we = 1'b0;
        tick();
        d_req_valid = 1'b0;
        tick();

        // Flush drops the previous fetch; the fetch issued alongside survives.
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        tick();
        if_req_addr = 32'h14; if_flush = 1'b1;
        tick();
        if_req_valid = 1'b0; if_flush = 1'b0;
        #1;
        chk("fetch_after_flush", {31'd0, if_rsp_valid}, 32'd1);
        tick();

        // Address wrap and a store with no byte enables.
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h00004004;
        #1;
        chk("wrap_addr", {20'd0, mem_addr}, 32'h001);
        tick();
        d_req_we = 1'b1; d_req_addr = 32'h180; d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'd0;
        tick();
        d_req_valid = 1'b0; d_req_we = 1'b0;
        #1;
        chk("zero_strb_ack", {31'd0, d_rsp_valid}, 32'd1);
        tick();

        // Reset while a load is in flight and the counter is non-zero.
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        d_req_valid = 1'b1; d_req_addr = 32'h300;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("starve_cnt_after_rst", {28'd0, dut.u_starve.cnt_reg}, 32'd0);
        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
